fsm_access_sched: RTL and testbench
===================================

// Module: fsm_access_sched
// PURPOSE
//  Round-robin scheduler that shares one condition-tracking FSM pair between NREQ requesters.
//  Per granted transaction it:
//   - clears the FSM pair;
//   - drives the two condition pulses in the requested order, plus the I strobe;
//   - waits for completion on the Ca status;
//   - returns the result to the requester.
//  Sits between the requesters and the FSM pair; it is the only driver of that pair's C1/C2/I/reset.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IDW      2   width of grant_id, equals $clog2(NREQ)
//  TIMEOUT  15  max WAIT cycles before error completion (1..2**TW-1)
//  TW       4   timeout counter width
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  req        in   NREQ  per-requester request level; held until done_o, dropping it aborts
//  order      in   NREQ  per-requester order bit, sampled at grant: 0 = C1 first, 1 = C2 first
//  ca_i       in   2     Ca status from the FSM pair
//  fsm_rst    out  1     active-high clear to the FSM pair
//  c1_o       out  1     C1 pulse to the FSM pair
//  c2_o       out  1     C2 pulse to the FSM pair
//  i_o        out  1     I strobe to the FSM pair
//  grant      out  NREQ  one-hot grant
//  grant_id   out  IDW   index of the granted requester
//  busy_o     out  1     high in any state except IDLE
//  done_o     out  1     one-cycle completion pulse
//  err_o      out  1     valid with done_o: timeout occurred
//  result_o   out  2     valid with done_o: ca_i sampled at completion
// BEHAVIOUR
//  Outputs: all registered.
//  Reset values: state = IDLE; rr pointer = NREQ-1 (requester 0 wins first); all outputs 0.
//  Reset mid-transaction: abandon at once, no done_o.
//  Arbitration (IDLE): winner is the first asserted req scanning from ptr+1 upward, with wrap.
//   - Latch winner into grant/grant_id and its order bit.
//   - Set ptr = winner.
//   - Go to CLR.
//  FSM states, 3-bit encoding; each state is one cycle unless noted:
//   - IDLE(0)
//   - CLR(1): fsm_rst = 1.
//   - FIRST(2): c1_o = 1 if order = 0, else c2_o = 1.
//   - ISSUE(3): i_o = 1.
//   - SECOND(4): pulse the other condition.
//   - WAIT(5): multi-cycle, see below.
//   - DONE(6): done_o = 1 -> IDLE.
//   - ABORT(7): fsm_rst = 1 -> IDLE.
//  WAIT:
//   - ca_i[0] = 1 -> DONE with err_o = 0 and result_o = ca_i.
//   - Otherwise increment tcnt; tcnt reaching TIMEOUT -> DONE with err_o = 1 and result_o = ca_i.
//   - tcnt clears on entry to WAIT.
//  Expected result codes: order 0 -> 2'b01; order 1 -> 2'b11.
//  grant/grant_id: held from CLR through DONE; cleared on return to IDLE.
//  Abort: granted requester drops req in CLR..WAIT -> ABORT (FSM pair cleared), no done_o, ptr still advanced.
//  Simultaneous events in WAIT:
//   - ca_i[0] = 1 and tcnt reaching TIMEOUT in the same cycle: success wins.
//   - req drop together with completion: abort wins.
//  Latency: req high at edge 0 gives grant at cycle 1, earliest done_o at cycle 6.
//   Back-to-back: IDLE costs 1 cycle, so the next grant comes 2 cycles after done_o.
//  Pulse exclusivity: at most one of c1_o/c2_o/i_o/fsm_rst is high in any cycle.
//  req still high after done_o: treated as a new request; round-robin prevents starvation.
// STRUCTURE
//  Shared package (fsm_pkg): state encoding constants; result codes CA_C1FIRST = 2'b01, CA_C2FIRST = 2'b11.
//  Sub-module rr_arbiter: combinational (req, ptr) -> (one-hot win, win_id, any).
//  Top holds the state register, tcnt, ptr and output registers.
// TESTING
//  1. req=0001, order=0, real FSM pair attached -> grant=0001 at cycle 1, c1 pulse at cycle 2, done_o at cycle 6,
//     result_o=01, err_o=0.
//  2. req=0010, order=0010 -> c2 pulse precedes i_o, done_o at cycle 6, result_o=11, grant_id=1.
//  3. req=1111 held continuously -> grants in sequence 0,1,2,3,0; each done_o 2 cycles before the next grant.
//  4. ca_i stubbed to 00, TIMEOUT=15 -> done_o exactly 16 cycles after WAIT entry, err_o=1, result_o=00.
//  5. Granted requester drops req in SECOND -> ABORT with fsm_rst high 1 cycle, no done_o, next requester
//     granted 2 cycles later.
//  6. reset asserted during WAIT -> all outputs 0 asynchronously; after release req=0100 is granted first
//     (ptr reset to NREQ-1).

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the access scheduler: state encoding and the
// result codes the condition-tracking FSM pair reports on success.
package fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_FIRST  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_SECOND = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ABORT  = 3'd7
  } state_e;

  localparam logic [1:0] CA_C1FIRST = 2'b01;
  localparam logic [1:0] CA_C2FIRST = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward
// from ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id,
  output logic            any
);

  function automatic int wrap_idx(input int base, input int step);
    return (base + step) % NREQ;
  endfunction

  // Scan from farthest to nearest so the nearest asserted request is written last.
  always_comb begin
    win    = {NREQ{1'b0}};
    win_id = {IDW{1'b0}};
    any    = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      win    = req[wrap_idx(int'(ptr), k)] ? (NREQ'(1) << wrap_idx(int'(ptr), k)) : win;
      win_id = req[wrap_idx(int'(ptr), k)] ? IDW'(wrap_idx(int'(ptr), k)) : win_id;
      any    = any | req[wrap_idx(int'(ptr), k)];
    end
  end

endmodule

// File: rtl/fsm_access_sched.sv
// Round-robin scheduler sharing one condition-tracking FSM pair between
// NREQ requesters: clear, ordered condition pulses, I strobe, completion.
module fsm_access_sched
  import fsm_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] order,
  input  logic [1:0]      ca_i,
  output logic            fsm_rst,
  output logic            c1_o,
  output logic            c2_o,
  output logic            i_o,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      result_o
);

  state_e          state_r;
  state_e          next_state_s;
  logic [IDW-1:0]  ptr_r;
  logic [TW-1:0]   tcnt_r;
  logic            order_r;
  logic [NREQ-1:0] win_s;
  logic [IDW-1:0]  win_id_s;
  logic            any_s;
  logic            drop_s;
  logic            fsm_rst_s;
  logic            c1_s;
  logic            c2_s;
  logic            i_s;
  logic            done_s;
  logic            err_s;
  logic [1:0]      result_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .win    (win_s),
    .win_id (win_id_s),
    .any    (any_s)
  );

  // The granted requester lowering its request line aborts the transaction.
  assign drop_s = ~|(req & grant);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort outranks completion, success outranks timeout.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   next_state_s = any_s ? ST_CLR : ST_IDLE;
      ST_CLR:    next_state_s = drop_s ? ST_ABORT : ST_FIRST;
      ST_FIRST:  next_state_s = drop_s ? ST_ABORT : ST_ISSUE;
      ST_ISSUE:  next_state_s = drop_s ? ST_ABORT : ST_SECOND;
      ST_SECOND: next_state_s = drop_s ? ST_ABORT : ST_WAIT;
      ST_WAIT: begin
        if (drop_s) begin
          next_state_s = ST_ABORT;
        end else if (ca_i[0] || (tcnt_r == TW'(TIMEOUT))) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE:   next_state_s = ST_IDLE;
      ST_ABORT:  next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output register lines up with its state.
  always_comb begin
    fsm_rst_s = 1'b0;
    c1_s      = 1'b0;
    c2_s      = 1'b0;
    i_s       = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    result_s  = 2'b00;
    case (next_state_s)
      ST_CLR:    fsm_rst_s = 1'b1;
      ST_ABORT:  fsm_rst_s = 1'b1;
      ST_FIRST: begin
        c1_s = ~order_r;
        c2_s = order_r;
      end
      ST_ISSUE:  i_s = 1'b1;
      ST_SECOND: begin
        c1_s = order_r;
        c2_s = ~order_r;
      end
      ST_DONE: begin
        done_s   = 1'b1;
        err_s    = ~ca_i[0];
        result_s = ca_i;
      end
      default: begin
        fsm_rst_s = 1'b0;
      end
    endcase
  end

  // Arbitration pointer, latched order bit and WAIT timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r   <= IDW'(NREQ - 1);
      order_r <= 1'b0;
      tcnt_r  <= {TW{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && any_s) begin
        ptr_r   <= win_id_s;
        order_r <= order[win_id_s];
      end else begin
        ptr_r   <= ptr_r;
        order_r <= order_r;
      end
      if (state_r != ST_WAIT) begin
        tcnt_r <= {TW{1'b0}};
      end else begin
        tcnt_r <= tcnt_r + TW'(1);
      end
    end
  end

  // Registered outputs; grant is held for the whole transaction and dropped in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_rst  <= 1'b0;
      c1_o     <= 1'b0;
      c2_o     <= 1'b0;
      i_o      <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      result_o <= 2'b00;
      grant    <= {NREQ{1'b0}};
      grant_id <= {IDW{1'b0}};
    end else begin
      fsm_rst  <= fsm_rst_s;
      c1_o     <= c1_s;
      c2_o     <= c2_s;
      i_o      <= i_s;
      busy_o   <= (next_state_s != ST_IDLE);
      done_o   <= done_s;
      err_o    <= err_s;
      result_o <= result_s;
      if (next_state_s == ST_IDLE) begin
        grant    <= {NREQ{1'b0}};
        grant_id <= {IDW{1'b0}};
      end else if (state_r == ST_IDLE) begin
        grant    <= win_s;
        grant_id <= win_id_s;
      end else begin
        grant    <= grant;
        grant_id <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fsm_access_sched.sv
// Directed bench for fsm_access_sched with a behavioural FSM pair and a
// scoreboard of expected completions checked whenever done_o fires.
module tb_fsm_access_sched;
  import fsm_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] res;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] order;
  logic [1:0] ca_i;
  logic       fsm_rst, c1_o, c2_o, i_o, busy_o, done_o, err_o;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [1:0] result_o;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  logic stub;
  logic [1:0] first_r;
  logic [1:0] ca_r;

  fsm_access_sched #(.NREQ(4), .IDW(2), .TIMEOUT(15), .TW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .order    (order),
    .ca_i     (ca_i),
    .fsm_rst  (fsm_rst),
    .c1_o     (c1_o),
    .c2_o     (c2_o),
    .i_o      (i_o),
    .grant    (grant),
    .grant_id (grant_id),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // FSM pair model: remembers which condition came first, reports it once both arrive.
  always @(posedge clk or posedge reset) begin
    if (reset || fsm_rst) begin
      first_r <= 2'd0;
      ca_r    <= 2'b00;
    end else if (c1_o || c2_o) begin
      if (first_r == 2'd0) first_r <= c1_o ? 2'd1 : 2'd2;
      else ca_r <= (first_r == 2'd1) ? CA_C1FIRST : CA_C2FIRST;
    end
  end
  assign ca_i = stub ? 2'b00 : ca_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Completion monitor and pulse exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      chk("pulse_excl", 32'($countones({fsm_rst, c1_o, c2_o, i_o}) <= 1), 32'd1);
      if (done_o) begin
        exp_t e;
        done_cnt++;
        chk("sb_nonempty_at_done", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("done_grant_id", 32'(grant_id), 32'(e.id));
          chk("done_result", 32'(result_o), 32'(e.res));
          chk("done_err", 32'(err_o), 32'(e.err));
        end
      end
    end
  end

  // One full transaction starting one cycle before the grant appears.
  task automatic txn(input int id, input logic ord, input bit drop);
    exp_t e;
    e.id = 2'(id);
    e.res = ord ? CA_C2FIRST : CA_C1FIRST;
    e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("grant_onehot", 32'(grant), 32'(1 << id));
    chk("clr_fsm_rst", 32'(fsm_rst), 32'd1);
    @(negedge clk);
    chk("first_c1", 32'(c1_o), 32'(!ord));
    chk("first_c2", 32'(c2_o), 32'(ord));
    @(negedge clk);
    chk("issue_i", 32'(i_o), 32'd1);
    @(negedge clk);
    chk("second_c1", 32'(c1_o), 32'(ord));
    chk("second_c2", 32'(c2_o), 32'(!ord));
    @(negedge clk);
    chk("wait_busy", 32'(busy_o), 32'd1);
    chk("wait_no_done", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("done_cycle6", 32'(done_o), 32'd1);
    if (drop) req = 4'b0000;
    @(negedge clk);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int dc;
    exp_t e;
    reset = 1'b1; req = 4'b0000; order = 4'b0000; stub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({fsm_rst, c1_o, c2_o, i_o, grant, grant_id, busy_o, done_o, err_o, result_o}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy_o), 32'd0);

    // Round robin with all requests held: 0,1,2,3,0, two-cycle gap after each done.
    req = 4'b1111; order = 4'b0000;
    for (int k = 0; k < 5; k++) txn(k % 4, 1'b0, k == 4);

    // Single requester 0, C1 first.
    req = 4'b0001; order = 4'b0000;
    txn(0, 1'b0, 1'b1);

    // Requester 1 with C2 first.
    req = 4'b0010; order = 4'b0010;
    txn(1, 1'b1, 1'b1);

    // Timeout: FSM pair stuck at 00, 16 WAIT cycles then error completion.
    stub = 1'b1; req = 4'b0100; order = 4'b0000;
    e.id = 2'd2; e.res = 2'b00; e.err = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    chk("to_grant_id", 32'(grant_id), 32'd2);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      chk("to_wait_no_done", 32'(done_o), 32'd0);
    end
    @(negedge clk);
    chk("to_done", 32'(done_o), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("to_idle", 32'(busy_o), 32'd0);
    stub = 1'b0;

    // Abort: requester 3 drops in SECOND; requester 0 granted two cycles after ABORT.
    req = 4'b1001; order = 4'b0000;
    dc = done_cnt;
    @(negedge clk);
    chk("ab_grant_id", 32'(grant_id), 32'd3);
    repeat (3) @(negedge clk);
    chk("ab_in_second", 32'(c2_o), 32'd1);
    req = 4'b0001;
    @(negedge clk);
    chk("ab_fsm_rst", 32'(fsm_rst), 32'd1);
    chk("ab_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("ab_idle_grant", 32'(grant), 32'd0);
    chk("ab_no_done", 32'(done_cnt), 32'(dc));
    txn(0, 1'b0, 1'b1);

    // Reset in WAIT: outputs clear asynchronously, pointer restarts at NREQ-1.
    req = 4'b0010; order = 4'b0000;
    @(negedge clk);
    chk("rw_grant_id", 32'(grant_id), 32'd1);
    repeat (4) @(negedge clk);
    chk("rw_in_wait", 32'(busy_o), 32'd1);
    #2 reset = 1'b1;
    #1 chk("rw_async_clear", 32'({fsm_rst, c1_o, c2_o, i_o, grant, grant_id, busy_o, done_o, err_o, result_o}), 32'd0);
    req = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    txn(1, 1'b0, 1'b1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
